// File: rtl/dda_wall_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : dda_wall_stepper
//  Purpose  : DDA grid traversal for one ray per screen column. It accepts a
//             ray from the setup stage and walks the map one cell per
//             iteration, reading the map BRAM each time. The walk ends on a
//             wall hit, on leaving the map, or when the step limit is
//             reached. It then presents hit cell, wall type, hit side and
//             perpendicular distance to the column renderer with a
//             valid/ready handshake.
//  Ports    :
//    pixel_clk_in, rst_in           clock, synchronous active-high reset
//    valid_ray_in / dda_data_ready_out
//                                   upstream handshake (ready only in IDLE)
//    hcount_in, stepX, stepY        column and step directions (1 = +1 cell)
//    sideDist*_in, deltaDist*_in    unsigned Q8.8 DDA distances
//    posX, posY                     Q8.8 player position (integer part = cell)
//    map_addr_out / map_data_in     map BRAM read port (MAP_LAT cycle latency)
//    valid_out / ready_in           downstream handshake
//    hcount_out, mapX_out, mapY_out, side_out, wall_type_out, perp_dist_out
//                                   result (type 4'hF = out of map,
//                                   4'h0 = step limit reached)
//  Revision : 1.0  initial release
// ============================================================================
module dda_wall_stepper #(
  parameter int MAP_N     = 24,
  parameter int MAP_AW    = 10,
  parameter int MAP_LAT   = 2,
  parameter int MAX_STEPS = 64
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              valid_ray_in,
  output logic              dda_data_ready_out,
  input  logic [8:0]        hcount_in,
  input  logic              stepX,
  input  logic              stepY,
  input  logic [15:0]       sideDistX_in,
  input  logic [15:0]       sideDistY_in,
  input  logic [15:0]       deltaDistX_in,
  input  logic [15:0]       deltaDistY_in,
  input  logic [15:0]       posX,
  input  logic [15:0]       posY,
  output logic [MAP_AW-1:0] map_addr_out,
  input  logic [3:0]        map_data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [8:0]        hcount_out,
  output logic [7:0]        mapX_out,
  output logic [7:0]        mapY_out,
  output logic              side_out,
  output logic [3:0]        wall_type_out,
  output logic [15:0]       perp_dist_out
);

  localparam int CNT_W  = $clog2(MAX_STEPS + 1);
  localparam int WAIT_W = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;

  localparam logic [7:0]        MAP_N_B     = 8'(MAP_N);
  localparam logic [CNT_W-1:0]  STEP_LIMIT  = CNT_W'(MAX_STEPS);
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(MAP_LAT - 1);
  localparam logic [3:0]        TYPE_OOB    = 4'hF;
  localparam logic [3:0]        TYPE_LIMIT  = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q;
  logic [8:0]        hcount_q;
  logic              stepx_q;
  logic              stepy_q;
  logic [15:0]       sdx_q;
  logic [15:0]       sdy_q;
  logic [15:0]       ddx_q;
  logic [15:0]       ddy_q;
  logic [7:0]        mapx_q;
  logic [7:0]        mapy_q;
  logic              side_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WAIT_W-1:0] wait_q;

  // Step datapath, evaluated from the current ray registers.
  logic              take_x_d;
  logic [16:0]       sum_x_d;
  logic [16:0]       sum_y_d;
  logic [15:0]       sat_x_d;
  logic [15:0]       sat_y_d;
  logic [7:0]        mapx_new_d;
  logic [7:0]        mapy_new_d;
  logic              oob_d;
  logic [MAP_AW-1:0] addr_d;
  logic [15:0]       perp_step_d;
  logic [15:0]       perp_chk_d;
  logic              unused_pos_d;

  // Strict less-than: a tie steps along Y.
  assign take_x_d = (sdx_q < sdy_q);

  assign sum_x_d = {1'b0, sdx_q} + {1'b0, ddx_q};
  assign sum_y_d = {1'b0, sdy_q} + {1'b0, ddy_q};
  assign sat_x_d = sum_x_d[16] ? 16'hFFFF : sum_x_d[15:0];
  assign sat_y_d = sum_y_d[16] ? 16'hFFFF : sum_y_d[15:0];

  // 8-bit wrap: stepping left from column 0 lands on 8'hFF, which the bounds
  // check below then rejects.
  assign mapx_new_d = !take_x_d ? mapx_q : (stepx_q ? mapx_q + 8'd1 : mapx_q - 8'd1);
  assign mapy_new_d =  take_x_d ? mapy_q : (stepy_q ? mapy_q + 8'd1 : mapy_q - 8'd1);

  assign oob_d  = (mapx_new_d >= MAP_N_B) || (mapy_new_d >= MAP_N_B);
  assign addr_d = MAP_AW'(mapy_new_d) * MAP_AW'(MAP_N) + MAP_AW'(mapx_new_d);

  // Perpendicular distance is the side distance before the last step, i.e.
  // the post-step value minus its delta. Saturated sums stay >= delta, so the
  // difference never goes negative.
  assign perp_step_d = take_x_d ? (sat_x_d - ddx_q) : (sat_y_d - ddy_q);
  assign perp_chk_d  = side_q ? (sdy_q - ddy_q) : (sdx_q - ddx_q);

  // Only the integer cell index of the position is needed.
  assign unused_pos_d = ^{posX[7:0], posY[7:0]};

  assign dda_data_ready_out = (state_q == S_IDLE);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      hcount_q      <= '0;
      stepx_q       <= 1'b0;
      stepy_q       <= 1'b0;
      sdx_q         <= '0;
      sdy_q         <= '0;
      ddx_q         <= '0;
      ddy_q         <= '0;
      mapx_q        <= '0;
      mapy_q        <= '0;
      side_q        <= 1'b0;
      cnt_q         <= '0;
      wait_q        <= '0;
      map_addr_out  <= '0;
      valid_out     <= 1'b0;
      hcount_out    <= '0;
      mapX_out      <= '0;
      mapY_out      <= '0;
      side_out      <= 1'b0;
      wall_type_out <= '0;
      perp_dist_out <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_ray_in) begin
            hcount_q <= hcount_in;
            stepx_q  <= stepX;
            stepy_q  <= stepY;
            sdx_q    <= sideDistX_in;
            sdy_q    <= sideDistY_in;
            ddx_q    <= deltaDistX_in;
            ddy_q    <= deltaDistY_in;
            mapx_q   <= posX[15:8];
            mapy_q   <= posY[15:8];
            side_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_STEP;
          end
        end

        S_STEP: begin
          cnt_q  <= cnt_q + CNT_W'(1);
          mapx_q <= mapx_new_d;
          mapy_q <= mapy_new_d;
          side_q <= !take_x_d;
          if (take_x_d) begin
            sdx_q <= sat_x_d;
          end else begin
            sdy_q <= sat_y_d;
          end
          if (oob_d) begin
            // Left the map: no BRAM read, report immediately.
            hcount_out    <= hcount_q;
            mapX_out      <= mapx_new_d;
            mapY_out      <= mapy_new_d;
            side_out      <= !take_x_d;
            wall_type_out <= TYPE_OOB;
            perp_dist_out <= perp_step_d;
            state_q       <= S_OUT;
          end else begin
            map_addr_out <= addr_d;
            wait_q       <= WAIT_RELOAD;
            state_q      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end

        S_CHECK: begin
          if (map_data_in != 4'h0) begin
            hcount_out    <= hcount_q;
            mapX_out      <= mapx_q;
            mapY_out      <= mapy_q;
            side_out      <= side_q;
            wall_type_out <= map_data_in;
            perp_dist_out <= perp_chk_d;
            state_q       <= S_OUT;
          end else if (cnt_q == STEP_LIMIT) begin
            hcount_out    <= hcount_q;
            mapX_out      <= mapx_q;
            mapY_out      <= mapy_q;
            side_out      <= side_q;
            wall_type_out <= TYPE_LIMIT;
            perp_dist_out <= 16'hFFFF;
            state_q       <= S_OUT;
          end else begin
            state_q <= S_STEP;
          end
        end

        S_OUT: begin
          // First OUT cycle raises valid; result fields were loaded on entry
          // and hold until the handshake completes.
          if (!valid_out) begin
            valid_out <= 1'b1;
          end else if (ready_in) begin
            valid_out <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
